eth_tx_frame_builder: RTL and testbench
=======================================

ETH_TX_FRAME_BUILDER -- requirements
Module: eth_tx_frame_builder

Interface
REQ-001 Parameter: AXIS_DATA_WIDTH, 64, payload/output beat width; only 64 is supported.
REQ-002 Parameter: LEN_WIDTH, 16, width of payload byte-size input.
REQ-003 Port: clk  in  1  single clock for all logic.
REQ-004 Port: rstn  in  1  reset, asynchronous, active-low.
REQ-005 Port: dst_addr / src_addr  in  48 each  MAC addresses, latched at frame start.
REQ-006 Port: eth_type  in  16  EtherType, latched at frame start.
REQ-007 Port: tx_size  in  LEN_WIDTH  expected payload bytes, latched at frame start.
REQ-008 Port: s_axis_tdata/tkeep/tvalid/tlast  in  64/8/1/1  payload stream from upstream generator.
REQ-009 Port: s_axis_tready  out  1  payload accept.
REQ-010 Port: m_axis_tdata/tkeep/tvalid/tlast  out  64/8/1/1  framed stream to MAC.
REQ-011 Port: m_axis_tready  in  1  MAC accept.
REQ-012 Port: len_err  out  1  one-cycle pulse, payload byte count != latched tx_size.
REQ-013 Port: frame_cnt  out  16  completed frames, wraps 0xFFFF->0.

Function
REQ-014 Byte order: byte i of a beat = tdata[8i+7:8i]; byte 0 first on wire; tkeep contiguous from bit 0; multi-byte fields sent MSB first.
REQ-015 Output register only: it loads when "adv" = !m_axis_tvalid | m_axis_tready; transfer occurs on tvalid&tready on each side.
REQ-016 States: IDLE, HDR1, PAYLOAD, FLUSH, PAD.
REQ-017 IDLE: s_axis_tready=0; if s_axis_tvalid & adv: latch dst/src/eth_type/tx_size, load beat0 = dst_addr bytes 47..0 + src_addr[47:32], tkeep 0xFF, -> HDR1.
REQ-018 HDR1: s_axis_tready=adv; on input transfer load beat1 = src_addr[31:0], eth_type, input bytes 0-1; store input bytes 2-7 in hold register, -> PAYLOAD (or tail handling REQ-020).
REQ-019 PAYLOAD: s_axis_tready=adv; each output beat = hold bytes (6) in bytes 0-5 + current input bytes 0-1 in bytes 6-7; hold reloads with input bytes 2-7.
REQ-020 Tail: last input beat with n valid bytes: n<=2 -> that output beat carries 6+n bytes and is the last payload beat; n>2 -> -> FLUSH, one extra beat with n-2 hold bytes, s_axis_tready=0.
REQ-021 Minimum frame 60 bytes (FCS excluded): if header+payload <60, unused bytes of the final payload beat are zero with tkeep set, then PAD emits zero beats until 60 bytes; final beat tkeep 0x0F.
REQ-022 m_axis_tlast=1 only on final beat (last payload/flush beat, or last PAD beat).
REQ-023 Payload byte counter is LEN_WIDTH+1 bits, sums popcount(tkeep) per input transfer; no wrap within a legal frame.
REQ-024 len_err pulses 1 cycle in the cycle the final output beat is loaded if count != latched tx_size; frame still completes.
REQ-025 On final beat transfer: frame_cnt +1, -> IDLE; output register empties, giving one idle cycle between frames.
REQ-026 No bytes dropped, duplicated or reordered under any m_axis_tready pattern; outputs hold stable while tvalid & !tready.
REQ-027 Inputs with s_axis_tvalid=0 stall the frame; output tvalid drops, state held.

Reset
REQ-028 rstn=0 asynchronously forces: state IDLE, m_axis_tvalid/tlast/len_err=0, m_axis_tdata=0, m_axis_tkeep=0, s_axis_tready=0, frame_cnt=0, counters/hold=0.
REQ-029 Reset mid-frame abandons the frame; next frame after release starts with beat0 header.

Verification
REQ-030 128 beats tkeep 0xFF, tx_size=1024, m_axis_tready=1 -> 130 beats, last tkeep 0x3F, len_err=0, frame_cnt=1.
REQ-031 127x0xFF + last 0x3F (1022 B), tx_size=1022 -> FLUSH used, 130 beats, last tkeep 0x0F, payload bytes match in order.
REQ-032 10-byte payload (0xFF, 0x03) -> 8 beats, bytes 24-59 zero, last tkeep 0x0F, tlast on beat 8.
REQ-033 Scenario REQ-030 with m_axis_tready pattern 1,0,1,0 and random s_axis_tvalid gaps -> identical output byte stream, no loss/duplication.
REQ-034 tx_size=1024, 1016 bytes sent -> len_err=1 for exactly one cycle with final beat; frame_cnt increments.
REQ-035 rstn pulsed low during beat 50 -> all outputs 0 immediately; next frame's first output beat is dst/src header.

Source files
------------

// File: rtl/eth_tx_frame_builder.sv
// Ethernet TX frame builder: prepends the dst/src/EtherType header to a 64-bit AXI-Stream
// payload, realigns the payload by the 14-byte header and pads short frames to 60 bytes.
module eth_tx_frame_builder #(
    parameter int unsigned AXIS_DATA_WIDTH = 64,
    parameter int unsigned LEN_WIDTH       = 16
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [47:0]                  dst_addr,
    input  logic [47:0]                  src_addr,
    input  logic [15:0]                  eth_type,
    input  logic [LEN_WIDTH-1:0]         tx_size,
    input  logic [AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                         s_axis_tvalid,
    input  logic                         s_axis_tlast,
    output logic                         s_axis_tready,
    output logic [AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                         m_axis_tvalid,
    output logic                         m_axis_tlast,
    input  logic                         m_axis_tready,
    output logic                         len_err,
    output logic [15:0]                  frame_cnt
);

    localparam int unsigned KEEP_W = AXIS_DATA_WIDTH / 8;
    localparam int unsigned CNT_W  = LEN_WIDTH + 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HDR1    = 3'd1;
    localparam logic [2:0] S_PAYLOAD = 3'd2;
    localparam logic [2:0] S_FLUSH   = 3'd3;
    localparam logic [2:0] S_PAD     = 3'd4;

    function automatic logic [63:0] rev_bytes(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = x[8*(7-i) +: 8];
        return r;
    endfunction

    function automatic logic [7:0] keep_mask(input logic [3:0] n);
        logic [8:0] m;
        m = (9'h1 << n) - 9'h1;
        return m[7:0];
    endfunction

    function automatic logic [63:0] byte_mask(input logic [7:0] k);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = {8{k[i]}};
        return r;
    endfunction

    function automatic logic [3:0] popcount(input logic [KEEP_W-1:0] k);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < int'(KEEP_W); i++) c = c + 4'(k[i]);
        return c;
    endfunction

    logic [2:0]       state, state_nxt;
    logic [31:0]      src_lo;
    logic [15:0]      type_q;
    logic [LEN_WIDTH-1:0] size_q;
    logic [47:0]      hold, hold_nxt;
    logic [3:0]       hold_n, hold_n_nxt;
    logic [3:0]       beat_idx;
    logic [CNT_W-1:0] byte_cnt, cnt_nxt;

    logic        adv, pend, in_xfer, start, load, ld_last, fin, tail;
    logic [3:0]  in_n, tail_n;
    logic [7:0]  ld_keep, mask_t;
    logic [63:0] ld_data;

    // The final beat sits in the output register until the MAC takes it; nothing else loads meanwhile.
    assign adv     = !m_axis_tvalid || m_axis_tready;
    assign pend    = m_axis_tvalid && m_axis_tlast;
    assign s_axis_tready = ((state == S_HDR1) || (state == S_PAYLOAD)) && adv && !pend;
    assign in_xfer = s_axis_tvalid && s_axis_tready;
    assign in_n    = popcount(s_axis_tkeep);
    assign cnt_nxt = byte_cnt + (in_xfer ? CNT_W'(in_n) : CNT_W'(0));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        start      = 1'b0;
        load       = 1'b0;
        ld_data    = '0;
        ld_keep    = '0;
        ld_last    = 1'b0;
        fin        = 1'b0;
        tail       = 1'b0;
        tail_n     = 4'd0;
        mask_t     = '0;
        hold_nxt   = hold;
        hold_n_nxt = hold_n;
        if (pend) begin
            if (m_axis_tready) state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (s_axis_tvalid && adv) begin
                        start     = 1'b1;
                        load      = 1'b1;
                        ld_data   = rev_bytes({dst_addr, src_addr[47:32]});
                        ld_keep   = 8'hFF;
                        state_nxt = S_HDR1;
                    end
                end
                S_HDR1, S_PAYLOAD: begin
                    if (in_xfer) begin
                        load     = 1'b1;
                        ld_keep  = 8'hFF;
                        ld_data  = (state == S_HDR1)
                                 ? (rev_bytes({src_lo, type_q, 16'h0}) | {s_axis_tdata[15:0], 48'h0})
                                 : {s_axis_tdata[15:0], hold};
                        hold_nxt = s_axis_tdata[63:16];
                        if (!s_axis_tlast) begin
                            state_nxt = S_PAYLOAD;
                        end else if (in_n <= 4'd2) begin
                            tail   = 1'b1;
                            tail_n = 4'd6 + in_n;
                        end else begin
                            hold_n_nxt = in_n - 4'd2;
                            state_nxt  = S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    if (adv) begin
                        load    = 1'b1;
                        ld_data = {16'h0, hold};
                        tail    = 1'b1;
                        tail_n  = hold_n;
                    end
                end
                S_PAD: begin
                    if (adv) begin
                        load   = 1'b1;
                        tail   = 1'b1;
                        tail_n = 4'd0;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
        // Last data beat: zero-fill it; before beat 7 keep padding, at beat 7 cut at byte 60.
        if (tail) begin
            mask_t  = keep_mask(tail_n);
            ld_data = ld_data & byte_mask(mask_t);
            if (beat_idx < 4'd7) begin
                ld_keep   = 8'hFF;
                state_nxt = S_PAD;
            end else begin
                ld_last = 1'b1;
                fin     = 1'b1;
                ld_keep = ((beat_idx == 4'd7) && (tail_n < 4'd4)) ? 8'h0F : mask_t;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            src_lo        <= '0;
            type_q        <= '0;
            size_q        <= '0;
            hold          <= '0;
            hold_n        <= '0;
            beat_idx      <= '0;
            byte_cnt      <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            len_err       <= 1'b0;
            frame_cnt     <= '0;
        end else begin
            if (start) begin
                src_lo   <= src_addr[31:0];
                type_q   <= eth_type;
                size_q   <= tx_size;
                byte_cnt <= '0;
                beat_idx <= 4'd1;
            end else begin
                byte_cnt <= cnt_nxt;
                if (load && (beat_idx != 4'd8)) beat_idx <= beat_idx + 4'd1;
            end
            hold   <= hold_nxt;
            hold_n <= hold_n_nxt;
            if (adv) begin
                m_axis_tvalid <= load;
                m_axis_tlast  <= ld_last;
                if (load) begin
                    m_axis_tdata <= ld_data;
                    m_axis_tkeep <= ld_keep;
                end
            end
            len_err <= fin && (cnt_nxt != CNT_W'(size_q));
            if (pend && m_axis_tready) frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_eth_tx_frame_builder.sv
// Directed bench for eth_tx_frame_builder: byte-stream scoreboard against a header+payload+pad
// model, plus beat count, tail keep, len_err, frame_cnt, stall stability and reset checks.
module tb_eth_tx_frame_builder;

    localparam int unsigned LW = 16;

    logic          clk = 1'b0;
    logic          rstn;
    logic [47:0]   dst_addr, src_addr;
    logic [15:0]   eth_type;
    logic [LW-1:0] tx_size;
    logic [63:0]   s_axis_tdata;
    logic [7:0]    s_axis_tkeep;
    logic          s_axis_tvalid, s_axis_tlast, s_axis_tready;
    logic [63:0]   m_axis_tdata;
    logic [7:0]    m_axis_tkeep;
    logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic          len_err;
    logic [15:0]   frame_cnt;

    always #5 clk = ~clk;

    eth_tx_frame_builder #(.AXIS_DATA_WIDTH(64), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rstn(rstn),
        .dst_addr(dst_addr), .src_addr(src_addr), .eth_type(eth_type), .tx_size(tx_size),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .len_err(len_err), .frame_cnt(frame_cnt)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [7:0]  got_q[$];
    logic [7:0]  exp_q[$];
    int          beats, tlast_cnt, lenerr_cnt, lenerr_last, stab_err, exp_frames;
    logic [7:0]  last_keep;
    logic [63:0] first_data;
    bit          frame_done, abort, rdy_toggle;
    logic        p_vld, p_last;
    logic [63:0] p_data;
    logic [7:0]  p_keep;

    task automatic clear_mon();
        got_q.delete();
        beats = 0; tlast_cnt = 0; lenerr_cnt = 0; lenerr_last = 0; stab_err = 0;
        last_keep = '0; first_data = '0; frame_done = 0;
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rstn) begin
            p_vld = 1'b0;
        end else begin
            if (p_vld && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== p_data ||
                          m_axis_tkeep !== p_keep || m_axis_tlast !== p_last))
                stab_err++;
            if (len_err === 1'b1) begin
                lenerr_cnt++;
                if (m_axis_tvalid && m_axis_tlast) lenerr_last++;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (beats == 0) first_data = m_axis_tdata;
                beats++;
                for (int i = 0; i < 8; i++)
                    if (m_axis_tkeep[i]) got_q.push_back(m_axis_tdata[8*i +: 8]);
                last_keep = m_axis_tkeep;
                if (m_axis_tlast) begin
                    tlast_cnt++;
                    frame_done = 1;
                end
            end
            p_vld  = m_axis_tvalid && !m_axis_tready;
            p_data = m_axis_tdata;
            p_keep = m_axis_tkeep;
            p_last = m_axis_tlast;
        end
    end

    always begin
        @(posedge clk);
        #1;
        m_axis_tready = rdy_toggle ? ~m_axis_tready : 1'b1;
    end

    function automatic logic [7:0] pay_byte(input logic [7:0] seed, input int idx);
        return 8'(seed + 8'(idx * 5) + 8'(idx >> 8));
    endfunction

    task automatic set_fields(input logic [7:0] seed, input logic [15:0] size);
        dst_addr = {8'h02, seed, 32'hA1B2C3D4};
        src_addr = {8'h0A, ~seed, 32'h11223344};
        eth_type = {8'h88, seed};
        tx_size  = size;
    endtask

    task automatic build_exp(input int nbeats, input logic [7:0] lkeep, input logic [7:0] seed);
        exp_q.delete();
        for (int i = 5; i >= 0; i--) exp_q.push_back(dst_addr[8*i +: 8]);
        for (int i = 5; i >= 0; i--) exp_q.push_back(src_addr[8*i +: 8]);
        exp_q.push_back(eth_type[15:8]);
        exp_q.push_back(eth_type[7:0]);
        for (int b = 0; b < nbeats; b++)
            for (int i = 0; i < 8; i++)
                if (((b == nbeats - 1) ? lkeep[i] : 1'b1)) exp_q.push_back(pay_byte(seed, b*8 + i));
        while (exp_q.size() < 60) exp_q.push_back(8'h00);
    endtask

    task automatic send_frame(input int nbeats, input logic [7:0] lkeep, input bit gaps,
                              input logic [7:0] seed);
        for (int b = 0; b < nbeats && !abort; b++) begin
            logic [7:0] k;
            int t;
            k = (b == nbeats - 1) ? lkeep : 8'hFF;
            if (gaps && $urandom_range(0, 2) == 0) begin
                s_axis_tvalid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            for (int i = 0; i < 8; i++)
                s_axis_tdata[8*i +: 8] = k[i] ? pay_byte(seed, b*8 + i) : 8'hEE;
            s_axis_tkeep  = k;
            s_axis_tlast  = (b == nbeats - 1);
            s_axis_tvalid = 1'b1;
            t = 0;
            forever begin
                @(negedge clk);
                if (abort || s_axis_tready) break;
                t++;
                if (t > 4000) begin
                    check("drv_timeout", 64'd1, 64'd0);
                    abort = 1;
                    break;
                end
            end
            if (!abort) begin
                @(posedge clk);
                #1;
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic run_frame(input string nm, input int nbeats, input logic [7:0] lkeep,
                             input logic [15:0] size, input bit gaps, input logic [7:0] seed,
                             input int exp_beats, input logic [7:0] exp_lkeep, input int exp_le);
        int t;
        int bad;
        logic [63:0] hdr;
        abort = 0;
        clear_mon();
        set_fields(seed, size);
        build_exp(nbeats, lkeep, seed);
        send_frame(nbeats, lkeep, gaps, seed);
        t = 0;
        while (!frame_done && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check({nm, "_done"}, 64'(frame_done), 64'd1);
        repeat (2) @(negedge clk);
        exp_frames++;
        bad = 0;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            if (got_q[i] !== exp_q[i]) bad++;
        for (int i = 0; i < 8; i++) hdr[8*i +: 8] = exp_q[i];
        check({nm, "_beats"},    64'(beats), 64'(exp_beats));
        check({nm, "_bytes"},    64'(got_q.size()), 64'(exp_q.size()));
        check({nm, "_byte_err"}, 64'(bad), 64'd0);
        check({nm, "_hdr0"},     first_data, hdr);
        check({nm, "_lastkeep"}, 64'(last_keep), 64'(exp_lkeep));
        check({nm, "_tlast"},    64'(tlast_cnt), 64'd1);
        check({nm, "_lenerr"},   64'(lenerr_cnt), 64'(exp_le));
        check({nm, "_le_last"},  64'(lenerr_last), 64'(exp_le));
        check({nm, "_stable"},   64'(stab_err), 64'd0);
        check({nm, "_fcnt"},     64'(frame_cnt), 64'(exp_frames));
    endtask

    initial begin
        rstn = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0;
        m_axis_tready = 1'b1; rdy_toggle = 0; abort = 0; exp_frames = 0;
        set_fields(8'h00, 16'd0);
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_tdata",  m_axis_tdata, 64'd0);
        check("rst_tready", 64'(s_axis_tready), 64'd0);
        check("rst_fcnt",   64'(frame_cnt), 64'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        run_frame("pad10",     2,   8'h03, 16'd10,   0, 8'h11, 8,   8'h0F, 0);
        run_frame("full1024",  128, 8'hFF, 16'd1024, 0, 8'h22, 130, 8'h3F, 0);
        run_frame("flush1022", 128, 8'h3F, 16'd1022, 0, 8'h33, 130, 8'h0F, 0);
        run_frame("tail1018",  128, 8'h03, 16'd1018, 0, 8'h44, 129, 8'hFF, 0);
        run_frame("one4",      1,   8'h0F, 16'd4,    0, 8'h55, 8,   8'h0F, 0);
        run_frame("min46",     6,   8'h3F, 16'd46,   0, 8'h66, 8,   8'h0F, 0);
        run_frame("min45",     6,   8'h1F, 16'd45,   0, 8'h77, 8,   8'h0F, 0);
        rdy_toggle = 1;
        run_frame("bp1024",    128, 8'hFF, 16'd1024, 1, 8'h22, 130, 8'h3F, 0);
        rdy_toggle = 0;
        run_frame("lenerr",    127, 8'hFF, 16'd1024, 0, 8'h88, 129, 8'h3F, 1);

        // Reset while beat 50 of a long frame is in flight.
        abort = 0;
        clear_mon();
        set_fields(8'h99, 16'd1024);
        fork
            send_frame(128, 8'hFF, 0, 8'h99);
            begin
                int t;
                t = 0;
                while (beats < 50 && t < 5000) begin
                    @(negedge clk);
                    t++;
                end
                check("mid_reached50", 64'(beats >= 50), 64'd1);
                #2;
                rstn  = 1'b0;
                abort = 1;
                #1;
                check("mid_tvalid", 64'(m_axis_tvalid), 64'd0);
                check("mid_tlast",  64'(m_axis_tlast), 64'd0);
                check("mid_tdata",  m_axis_tdata, 64'd0);
                check("mid_tkeep",  64'(m_axis_tkeep), 64'd0);
                check("mid_tready", 64'(s_axis_tready), 64'd0);
                check("mid_lenerr", 64'(len_err), 64'd0);
                check("mid_fcnt",   64'(frame_cnt), 64'd0);
            end
        join
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        exp_frames = 0;
        @(posedge clk);
        #1;
        run_frame("postrst",   2,   8'h03, 16'd10,   0, 8'hAB, 8,   8'h0F, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
